// File: rtl/cs_seq_arbiter.sv
// Round-robin arbiter sharing one 8-way chip-select bus among 4 requesters.
// Each grant runs a fixed setup / access / recover sequence with registered outputs.
module cs_seq_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ACC_CYC = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    dev,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [7:0]           cs_n,
    output logic                 busy
);

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StRecover
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [2:0]         dev_q, dev_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [7:0]         cs_n_q, cs_n_d;
    logic               busy_q, busy_d;

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    // First requester at or after the pointer, wrapping modulo 4.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            dev_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            cs_n_q  <= 8'hFF;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            dev_q   <= dev_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        dev_d   = dev_q;
        unique case (state_q)
            StIdle: begin
                if (en && win_valid) begin
                    owner_d = win_idx;
                    dev_d   = dev[3*win_idx +: 3];
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = CNT_W'(ACC_CYC - 1);
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StRecover;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRecover: begin
                ptr_d   = owner_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every output leaves a flop.
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        cs_n_d = 8'hFF;
        busy_d = (state_d != StIdle);
        if (state_d != StIdle) begin
            gnt_d[owner_d] = 1'b1;
        end
        if (state_d == StRecover) begin
            done_d[owner_d] = 1'b1;
        end
        if (state_d == StAccess) begin
            cs_n_d[dev_d] = 1'b0;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign cs_n = cs_n_q;
    assign busy = busy_q;

endmodule
